// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the hazard unit: forward selects,
// multiply FSM states and the PC register index.
package hazard_unit_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_M2 = 2'b11;

  localparam logic [3:0] PC_REG = 4'd15;

  typedef enum logic {
    RUN = 1'b0,
    MUL = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Per-operand forward select; the youngest matching writer wins.
// The PC register is never forwarded.
import hazard_unit_pkg::*;

module fwd_sel (
  input  logic [3:0] ra,
  input  logic [3:0] wa3M,
  input  logic [3:0] wa3W,
  input  logic [3:0] wa4M,
  input  logic       regWriteM,
  input  logic       regWriteW,
  input  logic       regWrite2M,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (ra != PC_REG) begin
      if (regWrite2M && wa4M == ra)
        fwd = FWD_M2;
      else if (regWriteM && wa3M == ra)
        fwd = FWD_M;
      else if (regWriteW && wa3W == ra)
        fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward control with a long-multiply hold FSM.
// HAZARD_FORWARD_EN enables forwarding; otherwise RAW hazards stall.
import hazard_unit_pkg::*;

module hazard_unit #(
  parameter int MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic [3:0] WA4M,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       RegWrite2M,
  input  logic       MemToRegE,
  input  logic       MulStartE,
  input  logic       BranchTakenE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       MulBusy
);

  localparam logic [2:0] CNT_LOAD = 3'(MUL_LAT - 2);

  state_t     state;
  state_t     stateNext;
  logic [2:0] cnt;
  logic [2:0] cntNext;
  logic [1:0] fwdA;
  logic [1:0] fwdB;
  logic       dataStall;
  logic       pcWrPend;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       flushD;
  logic       flushE;
  logic       flushM;

  fwd_sel uFwdA (
    .ra         (RA1E),
    .wa3M       (WA3M),
    .wa3W       (WA3W),
    .wa4M       (WA4M),
    .regWriteM  (RegWriteM),
    .regWriteW  (RegWriteW),
    .regWrite2M (RegWrite2M),
    .fwd        (fwdA)
  );

  fwd_sel uFwdB (
    .ra         (RA2E),
    .wa3M       (WA3M),
    .wa3W       (WA3W),
    .wa4M       (WA4M),
    .regWriteM  (RegWriteM),
    .regWriteW  (RegWriteW),
    .regWrite2M (RegWrite2M),
    .fwd        (fwdB)
  );

`ifdef HAZARD_FORWARD_EN
  assign dataStall = MemToRegE & RegWriteE &
                     (WA3E == RA1D | WA3E == RA2D);

  assign ForwardAE = reset ? fwdA : FWD_RF;
  assign ForwardBE = reset ? fwdB : FWD_RF;
`else
  logic rawA;
  logic rawB;
  logic unusedNoFwd;

  // W-stage producers are covered by regfile write-through.
  assign rawA = (RA1D != PC_REG) &
                ((RegWriteE & WA3E == RA1D) |
                 (RegWriteM & WA3M == RA1D) |
                 (RegWrite2M & WA4M == RA1D));
  assign rawB = (RA2D != PC_REG) &
                ((RegWriteE & WA3E == RA2D) |
                 (RegWriteM & WA3M == RA2D) |
                 (RegWrite2M & WA4M == RA2D));
  assign dataStall = rawA | rawB;

  assign ForwardAE = FWD_RF;
  assign ForwardBE = FWD_RF;
  assign unusedNoFwd = ^{fwdA, fwdB, MemToRegE};
`endif

  assign pcWrPend = PCSrcD | PCSrcE | PCSrcM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    unique case (state)
      RUN: begin
        stallF = dataStall | pcWrPend;
        stallD = dataStall;
        flushD = pcWrPend | PCSrcW | BranchTakenE;
        flushE = dataStall | BranchTakenE;
        if (MulStartE && !BranchTakenE) begin
          stateNext = MUL;
          cntNext   = CNT_LOAD;
        end
      end
      MUL: begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushM = 1'b1;
        if (cnt == 3'd0)
          stateNext = RUN;
        else
          cntNext = cnt - 3'd1;
      end
      default: ;
    endcase
  end

  assign StallF  = reset & stallF;
  assign StallD  = reset & stallD;
  assign StallE  = reset & stallE;
  assign FlushD  = reset & flushD;
  assign FlushE  = reset & flushE;
  assign FlushM  = reset & flushM;
  assign MulBusy = reset & (state == MUL);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
// Expectations follow HAZARD_FORWARD_EN when it is defined.
module tb_hazard_unit;

  localparam int MUL_LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1D, RA2D, RA1E, RA2E;
  logic [3:0] WA3E, WA3M, WA3W, WA4M;
  logic       RegWriteE, RegWriteM, RegWriteW, RegWrite2M;
  logic       MemToRegE, MulStartE, BranchTakenE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE;
  logic       FlushD, FlushE, FlushM, MulBusy;
  logic [6:0] ctl;

  int tests = 0;
  int fails = 0;

  hazard_unit #(.MUL_LAT(MUL_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .RA1E         (RA1E),
    .RA2E         (RA2E),
    .WA3E         (WA3E),
    .WA3M         (WA3M),
    .WA3W         (WA3W),
    .WA4M         (WA4M),
    .RegWriteE    (RegWriteE),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .RegWrite2M   (RegWrite2M),
    .MemToRegE    (MemToRegE),
    .MulStartE    (MulStartE),
    .BranchTakenE (BranchTakenE),
    .PCSrcD       (PCSrcD),
    .PCSrcE       (PCSrcE),
    .PCSrcM       (PCSrcM),
    .PCSrcW       (PCSrcW),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushM       (FlushM),
    .MulBusy      (MulBusy)
  );

  always #5 clk = ~clk;

  // {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy}
  assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy};

  task automatic clearIn();
    RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0;
    WA3E = 0; WA3M = 0; WA3W = 0; WA4M = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; RegWrite2M = 0;
    MemToRegE = 0; MulStartE = 0; BranchTakenE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clearIn();
    reset = 1'b0;
    RegWriteM = 1; WA3M = 3; RA1E = 3;
    MemToRegE = 1; RegWriteE = 1; WA3E = 2; RA2D = 2;
    PCSrcD = 1; MulStartE = 1;
    #1;
    tests++;
    if (ctl !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctl got=%b want=%b", ctl, 7'b0);
    end
    tests++;
    if (ForwardAE !== 2'b00) begin
      fails++;
      $display("FAIL reset_fwdA got=%b want=00", ForwardAE);
    end
    step();
    step();
    clearIn();
    #1;
    reset = 1'b1;
    step();
    tests++;
    if (ctl !== 7'b0) begin
      fails++;
      $display("FAIL reset_release got=%b want=%b", ctl, 7'b0);
    end
  endtask

  task automatic test_forward();
    logic [1:0] expA, expB;
    clearIn();
    RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3;
    #1;
`ifdef HAZARD_FORWARD_EN
    expA = 2'b10;
`else
    expA = 2'b00;
`endif
    tests++;
    if (ForwardAE !== expA) begin
      fails++;
      $display("FAIL fwd_a_m got=%b want=%b", ForwardAE, expA);
    end
    RegWriteM = 0;
    #1;
`ifdef HAZARD_FORWARD_EN
    expA = 2'b01;
`endif
    tests++;
    if (ForwardAE !== expA) begin
      fails++;
      $display("FAIL fwd_a_w got=%b want=%b", ForwardAE, expA);
    end
    RA1E = 15;
    #1;
    tests++;
    if (ForwardAE !== 2'b00) begin
      fails++;
      $display("FAIL fwd_a_r15 got=%b want=00", ForwardAE);
    end

    clearIn();
    RegWrite2M = 1; WA4M = 5; RegWriteM = 1; WA3M = 5; RA2E = 5;
    #1;
`ifdef HAZARD_FORWARD_EN
    expB = 2'b11;
`else
    expB = 2'b00;
`endif
    tests++;
    if (ForwardBE !== expB) begin
      fails++;
      $display("FAIL fwd_b_m2 got=%b want=%b", ForwardBE, expB);
    end
    RegWrite2M = 0;
    #1;
`ifdef HAZARD_FORWARD_EN
    expB = 2'b10;
`endif
    tests++;
    if (ForwardBE !== expB) begin
      fails++;
      $display("FAIL fwd_b_m got=%b want=%b", ForwardBE, expB);
    end
    RegWrite2M = 1; WA4M = 15; WA3M = 15; RegWriteW = 1; WA3W = 15;
    RA2E = 15;
    #1;
    tests++;
    if (ForwardBE !== 2'b00) begin
      fails++;
      $display("FAIL fwd_b_r15 got=%b want=00", ForwardBE);
    end
    RA2E = 9;
    #1;
    tests++;
    if (ForwardBE !== 2'b00) begin
      fails++;
      $display("FAIL fwd_b_none got=%b want=00", ForwardBE);
    end
  endtask

  task automatic test_load_stall();
    logic [6:0] exp2;
    clearIn();
    step();
    MemToRegE = 1; RegWriteE = 1; WA3E = 2; RA2D = 2;
    #1;
    tests++;
    if (ctl !== 7'b1100100) begin
      fails++;
      $display("FAIL ld_stall got=%b want=%b", ctl, 7'b1100100);
    end
    step();
    // load advances to M; consumer still waits in D
    MemToRegE = 0; RegWriteE = 0; WA3E = 0;
    RegWriteM = 1; WA3M = 2;
    #1;
`ifdef HAZARD_FORWARD_EN
    exp2 = 7'b0;
`else
    exp2 = 7'b1100100;
`endif
    tests++;
    if (ctl !== exp2) begin
      fails++;
      $display("FAIL ld_next got=%b want=%b", ctl, exp2);
    end
    clearIn();
    RA1D = 15; RegWriteM = 1; WA3M = 15;
    #1;
    tests++;
    if (ctl !== 7'b0) begin
      fails++;
      $display("FAIL raw_r15 got=%b want=%b", ctl, 7'b0);
    end
  endtask

  task automatic test_raw_stall();
    logic [6:0] exp;
    clearIn();
    RegWriteM = 1; WA3M = 4; RA1D = 4;
    #1;
`ifdef HAZARD_FORWARD_EN
    exp = 7'b0;
`else
    exp = 7'b1100100;
`endif
    tests++;
    if (ctl !== exp) begin
      fails++;
      $display("FAIL raw_m got=%b want=%b", ctl, exp);
    end
    tests++;
    if (ForwardAE !== 2'b00) begin
      fails++;
      $display("FAIL raw_fwdA got=%b want=00", ForwardAE);
    end
    clearIn();
    RegWrite2M = 1; WA4M = 7; RA2D = 7;
    #1;
    tests++;
    if (ctl !== exp) begin
      fails++;
      $display("FAIL raw_m2 got=%b want=%b", ctl, exp);
    end
    clearIn();
    RegWriteW = 1; WA3W = 4; RA1D = 4;
    #1;
    tests++;
    if (ctl !== 7'b0) begin
      fails++;
      $display("FAIL raw_w got=%b want=%b", ctl, 7'b0);
    end
  endtask

  task automatic test_branch();
    clearIn();
    PCSrcD = 1;
    #1;
    tests++;
    if (ctl !== 7'b1001000) begin
      fails++;
      $display("FAIL pc_pend got=%b want=%b", ctl, 7'b1001000);
    end
    clearIn();
    PCSrcW = 1;
    #1;
    tests++;
    if (ctl !== 7'b0001000) begin
      fails++;
      $display("FAIL pc_w got=%b want=%b", ctl, 7'b0001000);
    end
    clearIn();
    BranchTakenE = 1;
    #1;
    tests++;
    if (ctl !== 7'b0001100) begin
      fails++;
      $display("FAIL br_taken got=%b want=%b", ctl, 7'b0001100);
    end
    MulStartE = 1;
    step();
    tests++;
    if (MulBusy !== 1'b0) begin
      fails++;
      $display("FAIL br_blocks_mul got=%b want=0", MulBusy);
    end
    clearIn();
  endtask

  // Entry cycle runs in RUN, then MUL_LAT-1 held cycles:
  // the multiply sits in E for MUL_LAT cycles in total.
  task automatic test_mul();
    int busy;
    clearIn();
    step();
    MulStartE = 1;
    #1;
    tests++;
    if (ctl !== 7'b0) begin
      fails++;
      $display("FAIL mul_entry got=%b want=%b", ctl, 7'b0);
    end
    step();
    MulStartE = 0;
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (MulBusy !== 1'b1) break;
      tests++;
      if (ctl !== 7'b1110011) begin
        fails++;
        $display("FAIL mul_hold got=%b want=%b", ctl, 7'b1110011);
      end
      busy++;
      step();
    end
    tests++;
    if (busy != MUL_LAT - 1) begin
      fails++;
      $display("FAIL mul_len got=%0d want=%0d", busy, MUL_LAT - 1);
    end
    tests++;
    if (ctl !== 7'b0) begin
      fails++;
      $display("FAIL mul_done got=%b want=%b", ctl, 7'b0);
    end
  endtask

  task automatic test_mul_ldstall();
    int busy;
    clearIn();
    step();
    MulStartE = 1;
    MemToRegE = 1; RegWriteE = 1; WA3E = 6; RA1D = 6;
    #1;
    tests++;
    if (ctl !== 7'b1100100) begin
      fails++;
      $display("FAIL mulld_entry got=%b want=%b", ctl, 7'b1100100);
    end
    step();
    tests++;
    if (ctl !== 7'b1110011) begin
      fails++;
      $display("FAIL mulld_busy got=%b want=%b", ctl, 7'b1110011);
    end
    busy = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (MulBusy !== 1'b1) break;
      busy++;
    end
    tests++;
    if (busy != MUL_LAT - 1) begin
      fails++;
      $display("FAIL mulld_len got=%0d want=%0d", busy, MUL_LAT - 1);
    end
    clearIn();
    #1;
    tests++;
    if (ctl !== 7'b0) begin
      fails++;
      $display("FAIL mulld_after got=%b want=%b", ctl, 7'b0);
    end
  endtask

  task automatic test_reset_mid_mul();
    clearIn();
    step();
    MulStartE = 1;
    step();
    MulStartE = 0;
    step();
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (ctl !== 7'b0) begin
      fails++;
      $display("FAIL rstmid_ctl got=%b want=%b", ctl, 7'b0);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (ctl !== 7'b0) begin
        fails++;
        $display("FAIL rstmid_after got=%b want=%b", ctl, 7'b0);
      end
    end
  endtask

  always @(negedge clk) begin
    if (0) ;
  end

  initial begin
    test_reset();
    test_forward();
    test_load_stall();
    test_raw_stall();
    test_branch();
    test_mul();
    test_mul_ldstall();
    test_reset_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
